// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks a 4-input gate block through all 16 input vectors,
// holds each vector for SETTLE_CYCLES+1 cycles, samples e on the last cycle
// of the window, and accumulates the observed truth table plus a mismatch
// count against an expected table snapshotted at start.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_table,
    output logic [3:0]  vec_out,
    input  logic        dut_e,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // DRIVE occupies SETTLE_CYCLES cycles and SAMPLE one more, so with zero
    // settle cycles the DRIVE state is skipped and each vector lives in SAMPLE.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam state_t     WINDOW_START = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

    state_t      state_r, state_s;
    logic [3:0]  idx_r, idx_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [15:0] exp_r, exp_s;
    logic [15:0] table_r, table_s;
    logic [4:0]  mcnt_r, mcnt_s;
    logic        pass_r, pass_s;
    logic [3:0]  vec_r;
    logic        busy_r;
    logic        done_r;

    // Next-state and next-result computation for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        exp_s   = exp_r;
        table_s = table_r;
        mcnt_s  = mcnt_r;
        pass_s  = pass_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = WINDOW_START;
                    idx_s   = 4'd0;
                    cnt_s   = 4'd0;
                    exp_s   = exp_table;
                    table_s = 16'd0;
                    mcnt_s  = 5'd0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else if (cnt_r == SETTLE_LAST) begin
                    state_s = SAMPLE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else begin
                    table_s[idx_r] = dut_e;
                    if (dut_e != exp_r[idx_r]) begin
                        mcnt_s = mcnt_r + 5'd1;
                    end else begin
                        mcnt_s = mcnt_r;
                    end
                    if (idx_r == 4'd15) begin
                        state_s = DONE;
                        pass_s  = (mcnt_s == 5'd0);
                    end else begin
                        state_s = WINDOW_START;
                        idx_s   = idx_r + 4'd1;
                        cnt_s   = 4'd0;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, results and registered (glitch-free) outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
            cnt_r   <= 4'd0;
            exp_r   <= 16'd0;
            table_r <= 16'd0;
            mcnt_r  <= 5'd0;
            pass_r  <= 1'b0;
            vec_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            exp_r   <= exp_s;
            table_r <= table_s;
            mcnt_r  <= mcnt_s;
            pass_r  <= pass_s;
            vec_r   <= ((state_s == DRIVE) || (state_s == SAMPLE)) ? idx_s : 4'd0;
            busy_r  <= (state_s == DRIVE) || (state_s == SAMPLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign vec_out      = vec_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign truth_table  = table_r;
    assign mismatch_cnt = mcnt_r;
    assign pass         = pass_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed testbench for gate_sweep_ctrl: a default-settle instance driving a
// behavioural gate (e=0 only for abcd=1100) and a zero-settle instance with e tied 0.
module tb_gate_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] exp_table;
    logic [3:0]  vec0;
    logic        e0;
    logic        busy0;
    logic        done0;
    logic [15:0] tt0;
    logic [4:0]  mc0;
    logic        pass0;

    logic        start_z;
    logic        abort_z;
    logic [15:0] exp_z;
    logic [3:0]  vec_z;
    logic        e_z;
    logic        busy_z;
    logic        done_z;
    logic [15:0] tt_z;
    logic [4:0]  mc_z;
    logic        pass_z;

    int cmp_cnt = 0;
    int err_cnt = 0;

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_table(exp_table),
        .vec_out(vec0), .dut_e(e0), .busy(busy0), .done(done0),
        .truth_table(tt0), .mismatch_cnt(mc0), .pass(pass0)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .exp_table(exp_z),
        .vec_out(vec_z), .dut_e(e_z), .busy(busy_z), .done(done_z),
        .truth_table(tt_z), .mismatch_cnt(mc_z), .pass(pass_z)
    );

    // Gate block under sweep: e is low only for a=1,b=1,c=0,d=0.
    assign e0 = (vec0 != 4'd12);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep on the default instance and measure cycles to done.
    task automatic run_sweep(input logic [15:0] exp, output int lat, output bit seq_ok);
        exp_table = exp;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        seq_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (done0) begin
                lat = k;
                break;
            end
            if (vec0 !== 4'(k / 3)) seq_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        cmp_cnt++; if (vec0 !== 4'd0)   begin err_cnt++; $display("FAIL reset_vec got %h want 0", vec0); end
        cmp_cnt++; if (busy0 !== 1'b0)  begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy0); end
        cmp_cnt++; if (done0 !== 1'b0)  begin err_cnt++; $display("FAIL reset_done got %b want 0", done0); end
        cmp_cnt++; if (tt0 !== 16'h0)   begin err_cnt++; $display("FAIL reset_tt got %h want 0", tt0); end
        cmp_cnt++; if (mc0 !== 5'd0)    begin err_cnt++; $display("FAIL reset_mc got %0d want 0", mc0); end
        cmp_cnt++; if (pass0 !== 1'b0)  begin err_cnt++; $display("FAIL reset_pass got %b want 0", pass0); end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_golden();
        int lat;
        bit seq_ok;
        run_sweep(16'hEFFF, lat, seq_ok);
        cmp_cnt++; if (lat !== 48)       begin err_cnt++; $display("FAIL golden_latency got %0d want 48", lat); end
        cmp_cnt++; if (seq_ok !== 1'b1)  begin err_cnt++; $display("FAIL golden_vec_seq got %b want 1", seq_ok); end
        cmp_cnt++; if (busy0 !== 1'b0)   begin err_cnt++; $display("FAIL golden_busy_done got %b want 0", busy0); end
        cmp_cnt++; if (vec0 !== 4'd0)    begin err_cnt++; $display("FAIL golden_vec_done got %h want 0", vec0); end
        cmp_cnt++; if (tt0 !== 16'hEFFF) begin err_cnt++; $display("FAIL golden_tt got %h want efff", tt0); end
        cmp_cnt++; if (mc0 !== 5'd0)     begin err_cnt++; $display("FAIL golden_mc got %0d want 0", mc0); end
        cmp_cnt++; if (pass0 !== 1'b1)   begin err_cnt++; $display("FAIL golden_pass got %b want 1", pass0); end
        step();
        cmp_cnt++; if (done0 !== 1'b0)   begin err_cnt++; $display("FAIL golden_done_pulse got %b want 0", done0); end
        cmp_cnt++; if (pass0 !== 1'b1)   begin err_cnt++; $display("FAIL golden_pass_hold got %b want 1", pass0); end
    endtask

    task automatic test_mismatch();
        int lat;
        bit seq_ok;
        run_sweep(16'hFFFF, lat, seq_ok);
        cmp_cnt++; if (tt0 !== 16'hEFFF) begin err_cnt++; $display("FAIL mism1_tt got %h want efff", tt0); end
        cmp_cnt++; if (mc0 !== 5'd1)     begin err_cnt++; $display("FAIL mism1_mc got %0d want 1", mc0); end
        cmp_cnt++; if (pass0 !== 1'b0)   begin err_cnt++; $display("FAIL mism1_pass got %b want 0", pass0); end
        step();
        run_sweep(16'h1000, lat, seq_ok);
        cmp_cnt++; if (lat !== 48)       begin err_cnt++; $display("FAIL mism16_latency got %0d want 48", lat); end
        cmp_cnt++; if (mc0 !== 5'd16)    begin err_cnt++; $display("FAIL mism16_mc got %0d want 16", mc0); end
        cmp_cnt++; if (pass0 !== 1'b0)   begin err_cnt++; $display("FAIL mism16_pass got %b want 0", pass0); end
        step();
    endtask

    task automatic test_zero_settle();
        int lat;
        bit seq_ok;
        exp_z = 16'h0000;
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        lat = -1;
        seq_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done_z) begin
                lat = k;
                break;
            end
            if (vec_z !== 4'(k)) seq_ok = 1'b0;
        end
        cmp_cnt++; if (lat !== 16)       begin err_cnt++; $display("FAIL zs_latency got %0d want 16", lat); end
        cmp_cnt++; if (seq_ok !== 1'b1)  begin err_cnt++; $display("FAIL zs_vec_seq got %b want 1", seq_ok); end
        cmp_cnt++; if (tt_z !== 16'h0)   begin err_cnt++; $display("FAIL zs_tt got %h want 0", tt_z); end
        cmp_cnt++; if (mc_z !== 5'd0)    begin err_cnt++; $display("FAIL zs_mc got %0d want 0", mc_z); end
        cmp_cnt++; if (pass_z !== 1'b1)  begin err_cnt++; $display("FAIL zs_pass got %b want 1", pass_z); end
        step();
    endtask

    task automatic test_abort();
        bit seen;
        bit done_seen;
        exp_table = 16'hEFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (vec0 == 4'd5) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        cmp_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL abort_reach_vec5 got %b want 1", seen); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        cmp_cnt++; if (busy0 !== 1'b0)   begin err_cnt++; $display("FAIL abort_busy got %b want 0", busy0); end
        cmp_cnt++; if (vec0 !== 4'd0)    begin err_cnt++; $display("FAIL abort_vec got %h want 0", vec0); end
        cmp_cnt++; if (pass0 !== 1'b0)   begin err_cnt++; $display("FAIL abort_pass got %b want 0", pass0); end
        cmp_cnt++; if (tt0 !== 16'h001F) begin err_cnt++; $display("FAIL abort_tt got %h want 001f", tt0); end
        cmp_cnt++; if (mc0 !== 5'd0)     begin err_cnt++; $display("FAIL abort_mc got %0d want 0", mc0); end
        done_seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done0 || busy0) done_seen = 1'b1;
            step();
        end
        cmp_cnt++; if (done_seen !== 1'b0) begin err_cnt++; $display("FAIL abort_no_done got %b want 0", done_seen); end
    endtask

    task automatic test_restart_ignored();
        int lat;
        // start and abort together in IDLE: start wins
        exp_table = 16'hEFFF;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        cmp_cnt++; if (busy0 !== 1'b1) begin err_cnt++; $display("FAIL start_abort_busy got %b want 1", busy0); end
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k == 10) begin
                start = 1'b1;
                exp_table = 16'h0000;
            end
            if (k == 14) start = 1'b0;
            step();
            if (done0) begin
                lat = k;
                break;
            end
        end
        cmp_cnt++; if (lat !== 48)       begin err_cnt++; $display("FAIL restart_latency got %0d want 48", lat); end
        cmp_cnt++; if (tt0 !== 16'hEFFF) begin err_cnt++; $display("FAIL restart_tt got %h want efff", tt0); end
        cmp_cnt++; if (mc0 !== 5'd0)     begin err_cnt++; $display("FAIL restart_mc got %0d want 0", mc0); end
        cmp_cnt++; if (pass0 !== 1'b1)   begin err_cnt++; $display("FAIL restart_pass got %b want 1", pass0); end
        step();
    endtask

    task automatic test_async_reset();
        bit seen;
        int lat;
        bit seq_ok;
        exp_table = 16'hEFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (vec0 == 4'd9) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        cmp_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL arst_reach_vec9 got %b want 1", seen); end
        #2;
        rst = 1'b1;
        #1;
        cmp_cnt++; if (vec0 !== 4'd0)  begin err_cnt++; $display("FAIL arst_vec got %h want 0", vec0); end
        cmp_cnt++; if (busy0 !== 1'b0) begin err_cnt++; $display("FAIL arst_busy got %b want 0", busy0); end
        cmp_cnt++; if (tt0 !== 16'h0)  begin err_cnt++; $display("FAIL arst_tt got %h want 0", tt0); end
        cmp_cnt++; if (mc0 !== 5'd0)   begin err_cnt++; $display("FAIL arst_mc got %0d want 0", mc0); end
        step();
        rst = 1'b0;
        step();
        run_sweep(16'hEFFF, lat, seq_ok);
        cmp_cnt++; if (lat !== 48)       begin err_cnt++; $display("FAIL arst_resweep_latency got %0d want 48", lat); end
        cmp_cnt++; if (seq_ok !== 1'b1)  begin err_cnt++; $display("FAIL arst_resweep_seq got %b want 1", seq_ok); end
        cmp_cnt++; if (tt0 !== 16'hEFFF) begin err_cnt++; $display("FAIL arst_resweep_tt got %h want efff", tt0); end
        cmp_cnt++; if (pass0 !== 1'b1)   begin err_cnt++; $display("FAIL arst_resweep_pass got %b want 1", pass0); end
        step();
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        exp_table = 16'h0000;
        start_z = 1'b0;
        abort_z = 1'b0;
        exp_z = 16'h0000;
        e_z = 1'b0;
        test_reset();
        test_golden();
        test_mismatch();
        test_zero_settle();
        test_abort();
        test_restart_ignored();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
